spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 184 ++++++++++++++++++
 tb/tb_spi_slave.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave (mode 0: SCLK idle low, MOSI sampled on rising edge, MISO
// changed on falling edge). SCLK, SS and MOSI are oversampled by i_clk
// through 2-flop synchronizers; SCLK/SS carry a third stage for edge
// detection. Words are BITS long, MSB first, and may run back-to-back
// while SS stays low.
//
// Optional feature macro: SPI_SLAVE_OVERRUN_EN
//   defined   : o_valid holds until i_ack; a word completing while o_valid
//               is still high overwrites o_data and sets sticky o_ovr.
//   undefined : o_valid is a one-cycle pulse, i_ack ignored, o_ovr = 0.
module spi_slave #(
   parameter int unsigned BITS = 5
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_sclk,
   input  logic            i_ss,
   input  logic            i_mosi,
   output logic            o_miso,
   input  logic [BITS-1:0] i_data,
   input  logic            i_load,
   output logic [BITS-1:0] o_data,
   output logic            o_valid,
   input  logic            i_ack,
   output logic            o_busy,
   output logic            o_ovr
);

   localparam int unsigned CW = $clog2(BITS + 1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   // synchronizer chains: [0] first flop, [1] synchronized, [2] edge history
   logic [2:0]      sclk_q;
   logic [2:0]      ss_q;
   logic [1:0]      mosi_q;

   logic            sclk_rise;
   logic            sclk_fall;
   logic            ss_fall;
   logic            ss_rise;
   logic            mosi_s;

   state_t          state_q, state_d;
   logic [BITS-1:0] hold_q, hold_d;
   logic [BITS-1:0] tx_q, tx_d;
   logic [BITS-1:0] rx_q, rx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BITS-1:0] data_q, data_d;
   logic            valid_q, valid_d;
   logic            ovr_q, ovr_d;

   logic [BITS-1:0] hold_next;
   logic [BITS-1:0] rx_shift;
   logic            word_done;

   // synchronize the asynchronous SPI inputs into the i_clk domain
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sclk_q <= '0;
         ss_q   <= '0;
         mosi_q <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], i_sclk};
         ss_q   <= {ss_q[1:0], i_ss};
         mosi_q <= {mosi_q[0], i_mosi};
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign ss_fall   = ~ss_q[1] & ss_q[2];
   assign ss_rise   = ss_q[1] & ~ss_q[2];
   assign mosi_s    = mosi_q[1];

   // a load landing in the same cycle as a word-start reload must win
   assign hold_next = i_load ? i_data : hold_q;
   assign rx_shift  = BITS'({rx_q, mosi_s});

   // state and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   // next-state and datapath update
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_next;
      tx_d      = tx_q;
      rx_d      = rx_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      word_done = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = ACTIVE;
               tx_d    = hold_next;
               rx_d    = '0;
               cnt_d   = '0;
            end
         end

         ACTIVE: begin
            if (ss_rise) begin
               // partial word is dropped; o_data keeps the last full word
               state_d = IDLE;
               cnt_d   = '0;
            end else if (sclk_rise) begin
               rx_d = rx_shift;
               if (cnt_q == CW'(BITS - 1)) begin
                  word_done = 1'b1;
                  data_d    = rx_shift;
                  cnt_d     = '0;
                  tx_d      = hold_next;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (sclk_fall && (cnt_q != '0)) begin
               // with cnt_q == 0 the falling edge belongs to the previous
               // word's last bit; shifting would lose the reloaded MSB
               tx_d = tx_q << 1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   // o_valid held until acknowledged; unacknowledged completion is an overrun
   always_comb begin
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (word_done) begin
         valid_d = 1'b1;
         if (valid_q && !i_ack) begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && i_ack) begin
         valid_d = 1'b0;
      end
   end
`else
   logic unused_ack;

   // o_valid is a single-cycle pulse per completed word; no overrun tracking
   always_comb begin
      valid_d = word_done;
      ovr_d   = 1'b0;
   end

   assign unused_ack = i_ack;
`endif

   assign o_miso  = (state_q == ACTIVE) ? tx_q[BITS-1] : 1'b0;
   assign o_busy  = (state_q == ACTIVE);
   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_ovr   = ovr_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave (BITS = 5), acting as a mode-0 SPI master.
module tb_spi_slave;

   localparam int BITS = 5;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b1;
   logic            i_sclk = 1'b0;
   logic            i_ss = 1'b1;
   logic            i_mosi = 1'b0;
   logic            o_miso;
   logic [BITS-1:0] i_data = '0;
   logic            i_load = 1'b0;
   logic [BITS-1:0] o_data;
   logic            o_valid;
   logic            i_ack = 1'b0;
   logic            o_busy;
   logic            o_ovr;

   int checks = 0;
   int errors = 0;

   int              cyc = 0;
   int              last_rise = 0;
   int              vcount = 0;
   int              vhigh = 0;
   int              vdelay = 0;
   logic            vprev = 1'b0;
   logic [BITS-1:0] vlog[$];
   bit              auto_ack = 1'b1;
   logic [BITS-1:0] miso_got = '0;

   spi_slave #(.BITS(BITS)) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_sclk (i_sclk),
      .i_ss   (i_ss),
      .i_mosi (i_mosi),
      .o_miso (o_miso),
      .i_data (i_data),
      .i_load (i_load),
      .o_data (o_data),
      .o_valid(o_valid),
      .i_ack  (i_ack),
      .o_busy (o_busy),
      .o_ovr  (o_ovr)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // records o_valid events and acknowledges them when auto_ack is set
   always @(negedge i_clk) begin
      if (o_valid) begin
         vhigh++;
         if (!vprev) begin
            vcount++;
            vdelay = cyc - last_rise;
            vlog.push_back(o_data);
         end
      end
      vprev = o_valid;
      i_ack = auto_ack && o_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic ss_low();
      i_ss = 1'b0;
      tick(6);
   endtask

   task automatic ss_high();
      i_ss = 1'b1;
      tick(6);
   endtask

   // master: bits hi..lo of tx, SCLK half period 4 i_clk cycles
   task automatic send_bits(input logic [BITS-1:0] tx, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         i_mosi = tx[i];
         tick(4);
         miso_got[i] = o_miso;
         i_sclk = 1'b1;
         last_rise = cyc;
         tick(4);
         i_sclk = 1'b0;
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      tick(3);
      i_rst = 1'b0;
      tick(1);
      checks++; if (o_data !== 5'b00000) begin errors++; $display("FAIL reset_data: got %b expected 00000", o_data); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      checks++; if (o_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", o_miso); end
      checks++; if (o_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", o_ovr); end
   endtask

   task automatic test_basic_frame();
      int n0, h0;
      i_data = 5'b10110;
      i_load = 1'b1;
      tick(1);
      i_load = 1'b0;
      tick(2);
      checks++; if (o_miso !== 1'b0) begin errors++; $display("FAIL idle_miso: got %b expected 0", o_miso); end
      n0 = vcount;
      h0 = vhigh;
      ss_low();
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL active_busy: got %b expected 1", o_busy); end
      checks++; if (o_miso !== 1'b1) begin errors++; $display("FAIL active_miso_msb: got %b expected 1", o_miso); end
      send_bits(5'b01101, 4, 0);
      tick(4);
      ss_high();
      checks++; if (vcount !== n0 + 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected %0d", vcount, n0 + 1); end
      checks++; if (vdelay !== 3) begin errors++; $display("FAIL basic_valid_latency: got %0d expected 3", vdelay); end
      checks++; if (vhigh - h0 !== 1) begin errors++; $display("FAIL basic_valid_width: got %0d expected 1", vhigh - h0); end
      checks++; if (o_data !== 5'b01101) begin errors++; $display("FAIL basic_data: got %b expected 01101", o_data); end
      checks++; if (miso_got !== 5'b10110) begin errors++; $display("FAIL basic_miso: got %b expected 10110", miso_got); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", o_busy); end
   endtask

   task automatic test_back_to_back();
      int n0;
      logic [BITS-1:0] g1;
      i_data = 5'b11000;
      i_load = 1'b1;
      tick(1);
      i_load = 1'b0;
      n0 = vcount;
      ss_low();
      send_bits(5'b11111, 4, 0);
      g1 = miso_got;
      send_bits(5'b00001, 4, 0);
      tick(4);
      ss_high();
      checks++; if (vcount !== n0 + 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected %0d", vcount, n0 + 2); end
      if (vcount >= n0 + 2) begin
         checks++; if (vlog[n0] !== 5'b11111) begin errors++; $display("FAIL b2b_word1: got %b expected 11111", vlog[n0]); end
         checks++; if (vlog[n0+1] !== 5'b00001) begin errors++; $display("FAIL b2b_word2: got %b expected 00001", vlog[n0+1]); end
      end
      checks++; if (g1 !== 5'b11000) begin errors++; $display("FAIL b2b_miso1: got %b expected 11000", g1); end
      checks++; if (miso_got !== 5'b11000) begin errors++; $display("FAIL b2b_miso2: got %b expected 11000", miso_got); end
   endtask

   task automatic test_partial_abort();
      int n0;
      n0 = vcount;
      ss_low();
      send_bits(5'b10100, 4, 2);
      ss_high();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL partial_busy: got %b expected 0", o_busy); end
      checks++; if (vcount !== n0) begin errors++; $display("FAIL partial_no_valid: got %0d expected %0d", vcount, n0); end
      checks++; if (o_data !== 5'b00001) begin errors++; $display("FAIL partial_data_kept: got %b expected 00001", o_data); end
      ss_low();
      send_bits(5'b10011, 4, 0);
      tick(4);
      ss_high();
      checks++; if (vcount !== n0 + 1) begin errors++; $display("FAIL partial_next_count: got %0d expected %0d", vcount, n0 + 1); end
      checks++; if (o_data !== 5'b10011) begin errors++; $display("FAIL partial_next_data: got %b expected 10011", o_data); end
      checks++; if (miso_got !== 5'b11000) begin errors++; $display("FAIL partial_next_miso: got %b expected 11000", miso_got); end
   endtask

   task automatic test_load_midword();
      int n0;
      n0 = vcount;
      ss_low();
      send_bits(5'b01010, 4, 2);
      i_data = 5'b00111;
      i_load = 1'b1;
      tick(1);
      i_load = 1'b0;
      send_bits(5'b01010, 1, 0);
      checks++; if (miso_got !== 5'b11000) begin errors++; $display("FAIL load_mid_cur_miso: got %b expected 11000", miso_got); end
      send_bits(5'b10101, 4, 0);
      checks++; if (miso_got !== 5'b00111) begin errors++; $display("FAIL load_mid_next_miso: got %b expected 00111", miso_got); end
      tick(4);
      ss_high();
      checks++; if (vcount !== n0 + 2) begin errors++; $display("FAIL load_mid_count: got %0d expected %0d", vcount, n0 + 2); end
      if (vcount >= n0 + 2) begin
         checks++; if (vlog[n0] !== 5'b01010) begin errors++; $display("FAIL load_mid_word1: got %b expected 01010", vlog[n0]); end
         checks++; if (vlog[n0+1] !== 5'b10101) begin errors++; $display("FAIL load_mid_word2: got %b expected 10101", vlog[n0+1]); end
      end
   endtask

   task automatic test_load_at_reload();
      logic [BITS-1:0] g1;
      ss_low();
      send_bits(5'b11100, 4, 1);
      i_mosi = 1'b0;
      tick(4);
      miso_got[0] = o_miso;
      i_sclk = 1'b1;
      last_rise = cyc;
      tick(2);
      // strobe lands on the same i_clk edge that completes the word
      i_data = 5'b11010;
      i_load = 1'b1;
      tick(1);
      i_load = 1'b0;
      tick(1);
      i_sclk = 1'b0;
      g1 = miso_got;
      send_bits(5'b00011, 4, 0);
      tick(4);
      ss_high();
      checks++; if (g1 !== 5'b00111) begin errors++; $display("FAIL load_reload_cur_miso: got %b expected 00111", g1); end
      checks++; if (miso_got !== 5'b11010) begin errors++; $display("FAIL load_reload_next_miso: got %b expected 11010", miso_got); end
      checks++; if (o_data !== 5'b00011) begin errors++; $display("FAIL load_reload_data: got %b expected 00011", o_data); end
   endtask

   task automatic test_overrun();
      int n0, h0;
      n0 = vcount;
      h0 = vhigh;
      auto_ack = 1'b0;
      ss_low();
      send_bits(5'b10001, 4, 0);
      send_bits(5'b01110, 4, 0);
      tick(4);
      ss_high();
      checks++; if (o_data !== 5'b01110) begin errors++; $display("FAIL ovr_data: got %b expected 01110", o_data); end
`ifdef SPI_SLAVE_OVERRUN_EN
      checks++; if (o_ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", o_ovr); end
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", o_valid); end
      checks++; if (vcount !== n0 + 1) begin errors++; $display("FAIL ovr_valid_count: got %0d expected %0d", vcount, n0 + 1); end
      auto_ack = 1'b1;
      tick(3);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack_clears: got %b expected 0", o_valid); end
      checks++; if (o_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", o_ovr); end
`else
      checks++; if (o_ovr !== 1'b0) begin errors++; $display("FAIL ovr_flag: got %b expected 0", o_ovr); end
      checks++; if (vcount !== n0 + 2) begin errors++; $display("FAIL ovr_pulse_count: got %0d expected %0d", vcount, n0 + 2); end
      checks++; if (vhigh - h0 !== 2) begin errors++; $display("FAIL ovr_pulse_width: got %0d expected 2", vhigh - h0); end
      auto_ack = 1'b1;
`endif
   endtask

   task automatic test_reset_midframe();
      int n0;
      ss_low();
      send_bits(5'b11011, 4, 3);
      i_rst = 1'b1;
      tick(1);
      i_rst = 1'b0;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", o_busy); end
      checks++; if (o_data !== 5'b00000) begin errors++; $display("FAIL rst_mid_data: got %b expected 00000", o_data); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", o_valid); end
      checks++; if (o_miso !== 1'b0) begin errors++; $display("FAIL rst_mid_miso: got %b expected 0", o_miso); end
      checks++; if (o_ovr !== 1'b0) begin errors++; $display("FAIL rst_mid_ovr: got %b expected 0", o_ovr); end
      n0 = vcount;
      send_bits(5'b11011, 2, 0);
      send_bits(5'b11011, 4, 3);
      tick(4);
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_stays_idle: got %b expected 0", o_busy); end
      checks++; if (vcount !== n0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d expected %0d", vcount, n0); end
      ss_high();
      ss_low();
      send_bits(5'b10101, 4, 0);
      tick(4);
      ss_high();
      checks++; if (o_data !== 5'b10101) begin errors++; $display("FAIL rst_fresh_data: got %b expected 10101", o_data); end
      checks++; if (miso_got !== 5'b00000) begin errors++; $display("FAIL rst_fresh_miso: got %b expected 00000", miso_got); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_partial_abort();
      test_load_midword();
      test_load_at_reload();
      test_overrun();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
